frame_buffer_uart_streamer: RTL
===============================

// Module: frame_buffer_uart_streamer
// PURPOSE
// Drain side of the packed edge-frame buffer. The canny packer writes 1-bit pixels,
// 8 per byte, into a DEPTH-byte RAM and pulses frame_tick when the frame is complete.
// This block takes that tick and reads bytes 0..DEPTH-1 in order. It sends a SYNC
// byte, then every frame byte, to the uart_tx byte interface. It pulses done at the end.
// PARAMETERS
// DEPTH    5100   bytes per packed frame (= pixels/8)
// ADDR_W   $clog2(DEPTH)   RAM address width
// SYNC     8'hA5  header byte sent before byte 0 of each frame
// PORTS
// clk       in   1       system clock
// reset     in   1       synchronous, active-high reset
// start     in   1       1-cycle frame-ready pulse (packer frame_tick)
// rAddr     out  ADDR_W  frame RAM read address
// rData     in   8       frame RAM read data, valid 1 clk after rAddr (registered RAM)
// tx_data   out  8       byte to uart_tx
// tx_start  out  1       1-cycle send strobe to uart_tx
// tx_busy   in   1       uart_tx busy; rises <=1 clk after tx_start, falls after stop bit
// busy      out  1       high from accepted start until done pulse (inclusive)
// done      out  1       1-cycle pulse after the last frame byte's stop bit
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high. All outputs are registered.
// - Reset values: rAddr=0, tx_data=0, tx_start=0, busy=0, done=0, state=IDLE.
// - Reset in any state aborts at once. No done pulse. A byte already in flight in
//   uart_tx is not recalled.
// - States: IDLE, SYNC, RD, RD_WAIT, SEND, TX_GUARD, TX_WAIT, DONE.
//   IDLE: start=1 -> SYNC; busy<=1; rAddr<=0.
//   SYNC: wait until tx_busy=0. Then tx_data<=SYNC, tx_start<=1, -> TX_GUARD (hdr flag set).
//   RD: present rAddr -> RD_WAIT.
//   RD_WAIT: 1-clk RAM latency -> SEND.
//   SEND: requires tx_busy=0. Then tx_data<=rData, tx_start<=1 for 1 clk, -> TX_GUARD.
//   TX_GUARD: 1 clk, tx_busy ignored; covers uart_tx busy-rise latency -> TX_WAIT.
//   TX_WAIT: wait for tx_busy=0.
//     After hdr -> RD (hdr flag cleared).
//     Else if rAddr==DEPTH-1 -> DONE.
//     Else rAddr<=rAddr+1 -> RD.
//   DONE: done<=1 for 1 clk, busy<=0, rAddr<=0 -> IDLE.
// - Ordering: SYNC, then RAM bytes 0,1,...,DEPTH-1. Exactly DEPTH+1 tx_start pulses
//   per frame.
// - tx_start is never asserted while tx_busy=1. It is never asserted on 2 consecutive clks.
// - rAddr stays constant from RD through TX_WAIT. It never exceeds DEPTH-1 and never wraps.
// - start while busy=1 (any state but IDLE) is ignored and is not queued.
// - start on the same clk as the DONE state: ignored. It is accepted only in IDLE.
// - tx_busy already high when start arrives: SYNC state stalls until it clears.
// - Throughput is bounded by UART. Per-byte overhead beyond the UART frame is <=4 clks.
// STRUCTURE
// - Shared package uart_pkg:
//   - typedef enum logic [2:0] stream_state_t for the 8 states
//   - localparam FRAME_BYTES=5100; localparam SYNC_BYTE=8'hA5
//   - the packer uses FRAME_BYTES from the same package
// - Single module; FSM plus address counter. No sub-module is needed.
// - The bench pairs this block with a behavioural RAM model and a uart_tx model.
// TESTING
// 1 reset, then start pulse, DEPTH=4, RAM={11,22,33,44}
//   -> tx bytes A5,11,22,33,44; done 1 clk after the last busy fall; busy low after.
// 2 uart_tx model with busy-rise latency 0 and 1 clk
//   -> no tx_start while tx_busy=1; no byte dropped or duplicated.
// 3 start pulses at byte 2 and on the done clk
//   -> both ignored; exactly 5 bytes sent; next start in IDLE sends a fresh frame.
// 4 reset asserted at byte 3 of a 5100-byte frame
//   -> all outputs 0 next clk; no done; the next start restarts from SYNC with rAddr=0.
// 5 full DEPTH=5100 frame, RAM[i]=i[7:0]
//   -> 5101 bytes; last rAddr=5099; rAddr back to 0 after done; scoreboard matches.
// 6 tx_busy held high for 50 clks when start arrives
//   -> SYNC byte is sent only after tx_busy falls.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the packed edge-frame path: drain FSM states and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RD,
    ST_RD_WAIT,
    ST_SEND,
    ST_TX_GUARD,
    ST_TX_WAIT,
    ST_DONE
  } stream_state_t;

  localparam int unsigned FRAME_BYTES = 5100;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

endpackage

// File: rtl/frame_buffer_uart_streamer.sv
// Drains the packed frame RAM to the uart_tx byte interface: a SYNC header byte,
// then bytes 0..DEPTH-1 in order, then a one-cycle done pulse.
module frame_buffer_uart_streamer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = FRAME_BYTES,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [7:0]        rData,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  stream_state_t     state, state_n;
  logic              hdr, hdr_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;
  logic              start_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // All outputs come straight from flops; the comb block only computes their next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr      <= 1'b0;
      rAddr    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      hdr      <= hdr_n;
      rAddr    <= addr_n;
      tx_data  <= data_n;
      tx_start <= start_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    hdr_n   = hdr;
    addr_n  = rAddr;
    data_n  = tx_data;
    start_n = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SYNC;
          busy_n  = 1'b1;
          addr_n  = '0;
        end
      end
      ST_SYNC: begin
        if (!tx_busy) begin
          data_n  = SYNC;
          start_n = 1'b1;
          hdr_n   = 1'b1;
          state_n = ST_TX_GUARD;
        end
      end
      ST_RD:      state_n = ST_RD_WAIT;
      ST_RD_WAIT: state_n = ST_SEND;
      ST_SEND: begin
        if (!tx_busy) begin
          data_n  = rData;
          start_n = 1'b1;
          state_n = ST_TX_GUARD;
        end
      end
      // uart_tx may take a clock to raise busy after the strobe
      ST_TX_GUARD: state_n = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          if (hdr) begin
            hdr_n   = 1'b0;
            state_n = ST_RD;
          end else if (rAddr == LAST_ADDR) begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            addr_n  = rAddr + ADDR_W'(1);
            state_n = ST_RD;
          end
        end
      end
      // done is registered on entry so it is high during this state while busy still is
      ST_DONE: begin
        busy_n  = 1'b0;
        addr_n  = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
